// File: rtl/uart_pkg.sv
// Shared types and constants for the UART pixel loader.
// Receiver state enum, baud divider helper, break byte value.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [7:0] BREAK_BYTE = 8'h00;

  // Clock cycles per bit, or half of that for the start-bit centre.
  function automatic int baud_div(
    input int clk_freq,
    input int bps,
    input bit half
  );
    int b;
    b = clk_freq / bps;
    return half ? (b / 2) : b;
  endfunction

endpackage

// File: rtl/uart_pixel_loader_if.sv
// Pixel write handshake toward the frame-buffer FIFO.
// master: pix_valid/pix_data/pix_addr out, pix_ready in.
interface uart_pixel_loader_if #(
  parameter int ADDR_W = 19
) ();

  logic              pix_valid;
  logic [15:0]       pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_ready;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_addr,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_addr,
    output pix_ready
  );

endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: rx synchroniser, IDLE/START/DATA/STOP FSM.
// Ports: sys_clk, sys_rst, rx in; rx_byte, byte_ok, byte_ferr, is_break out.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       byte_ferr,
  output logic       is_break
);

  localparam int BAUD = baud_div(CLK_FREQ, UART_BPS, 1'b0);
  localparam int HALF = baud_div(CLK_FREQ, UART_BPS, 1'b1);
  localparam int CW   = $clog2(BAUD);

  localparam logic [CW-1:0] LAST  = CW'(BAUD - 1);
  localparam logic [CW-1:0] HLAST = CW'(HALF - 1);

  rx_state_t state, nxt;

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;

  assign rx_s    = sync[1];
  assign rx_byte = shreg;

  // START times out at mid-bit, every other state at a full bit.
  always_comb begin
    tick = 1'b0;
    if (state == START) tick = (cnt == HLAST);
    else                tick = (cnt == LAST);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync <= 2'b11;
      rx_d <= 1'b1;
    end else begin
      sync <= {sync[0], rx};
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (rx_d && !rx_s) nxt = START;
      START: if (tick) nxt = rx_s ? IDLE : DATA;
      DATA:  if (tick && bit_idx == 3'd7) nxt = STOP;
      STOP:  if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // bit_idx wraps 7->0 on the last data bit, so it is 0 on entry.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
      if (state == DATA && tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    byte_ok   = 1'b0;
    byte_ferr = 1'b0;
    is_break  = 1'b0;
    if (state == STOP && tick) begin
      byte_ok   = rx_s;
      byte_ferr = !rx_s;
      is_break  = !rx_s && (shreg == BREAK_BYTE);
    end
  end

endmodule

// File: rtl/uart_pixel_loader.sv
// UART to frame-buffer pixel loader: packs bytes into pixels, addresses.
// Ports: sys_clk, sys_rst, rx, clr_err, pix (master), frame_done, errs.
// Option: UART_BREAK_SYNC_EN turns a break into a frame resync.
module uart_pixel_loader
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int PIX_BYTES = 1,
  parameter int FRAME_PIX = 307200,
  parameter int ADDR_W    = 19
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic rx,
  input  logic clr_err,
  uart_pixel_loader_if.master pix,
  output logic frame_done,
  output logic err_frame,
  output logic err_overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(FRAME_PIX - 1);

  logic [7:0]  rx_byte;
  logic        byte_ok;
  logic        byte_ferr;
  logic        is_break;
  logic        byte_idx;
  logic [7:0]  lo_byte;
  logic [15:0] new_word;
  logic        pix_done;
  logic        hs;
  logic        ovr_evt;
  logic        ferr_evt;
  logic        brk;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_rx (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_ok   (byte_ok),
    .byte_ferr (byte_ferr),
    .is_break  (is_break)
  );

`ifdef UART_BREAK_SYNC_EN
  assign brk      = is_break;
  assign ferr_evt = byte_ferr && !is_break;
`else
  // A break is just a framing error here.
  assign brk      = 1'b0;
  assign ferr_evt = byte_ferr || is_break;
`endif

  always_comb begin
    if (PIX_BYTES == 1) begin
      new_word = {8'h00, rx_byte};
      pix_done = byte_ok;
    end else begin
      new_word = {rx_byte, lo_byte};
      pix_done = byte_ok && byte_idx;
    end
  end

  assign hs         = pix.pix_valid && pix.pix_ready;
  assign frame_done = hs && (pix.pix_addr == LAST_ADDR);
  assign ovr_evt    = pix_done && pix.pix_valid && !pix.pix_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || brk) begin
      byte_idx <= 1'b0;
    end else if (byte_ok && PIX_BYTES == 2) begin
      byte_idx <= !byte_idx;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) lo_byte <= '0;
    else if (byte_ok && !byte_idx) lo_byte <= rx_byte;
  end

  // A pixel completing in the handshake cycle replaces the old one.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pix.pix_valid <= 1'b0;
      pix.pix_data  <= '0;
    end else if (brk) begin
      pix.pix_valid <= 1'b0;
    end else if (pix_done && !ovr_evt) begin
      pix.pix_valid <= 1'b1;
      pix.pix_data  <= new_word;
    end else if (hs) begin
      pix.pix_valid <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || brk) begin
      pix.pix_addr <= '0;
    end else if (hs) begin
      if (pix.pix_addr == LAST_ADDR) pix.pix_addr <= '0;
      else pix.pix_addr <= pix.pix_addr + 1'b1;
    end
  end

  // A new error event wins over a simultaneous clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (ferr_evt)     err_frame <= 1'b1;
      else if (clr_err) err_frame <= 1'b0;
      if (ovr_evt)      err_overrun <= 1'b1;
      else if (clr_err) err_overrun <= 1'b0;
    end
  end

endmodule

// File: doc/uart_pixel_loader.md
# uart_pixel_loader

Parametrised successor to the single-byte UART receive path that feeds the SDRAM frame-buffer write port. It oversamples a serial line, assembles 1 or 2 received bytes into one pixel word, and presents the word with a frame-relative write address over a valid/ready handshake to the frame-buffer write FIFO. It also detects framing errors, detects overruns and wraps at end of frame. It sits between the GPIO receive pin and the Sdram_Control write side 1.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- UART_BPS, 115200, line rate; BAUD_CNT = CLK_FREQ/UART_BPS (integer division), must be ≥ 16
- PIX_BYTES, 1, bytes per pixel, legal values 1 or 2
- FRAME_PIX, 307200, pixels per frame (640*480)
- ADDR_W, 19, address width, must satisfy 2^ADDR_W ≥ FRAME_PIX

- sys_clk  in  1  single clock; all logic is on its rising edge
- sys_rst  in  1  reset, synchronous and active-high
- rx  in  1  asynchronous serial input, idle high
- pix_ready  in  1  sink can accept a pixel this cycle
- clr_err  in  1  clears both sticky error flags
- pix_valid  out  1  pix_data/pix_addr are valid
- pix_data  out  16  pixel; byte 0 in [7:0], byte 1 in [15:8]; unused bits are 0
- pix_addr  out  ADDR_W  pixel index within frame
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted
- err_frame  out  1  sticky; a stop bit was sampled low
- err_overrun  out  1  sticky; a pixel was dropped because the holding register was full

## Operation
- rx passes through a 2-flop synchroniser; both flops reset to 1.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on the synchronised falling edge.
  - START waits BAUD_CNT/2 cycles, then re-samples. If the sample is high it returns to IDLE (glitch). If low it goes to DATA.
  - DATA samples 8 bits LSB-first, one every BAUD_CNT cycles.
  - STOP samples once after BAUD_CNT cycles. High: byte accepted. Low: byte discarded and err_frame set. Either way the FSM returns to IDLE.
- Packer:
  - A byte index counts 0..PIX_BYTES-1. Accepted bytes fill the pixel shift register at that index.
  - When the index wraps, the pixel moves to a single-entry holding register and pix_valid is set.
  - If a pixel completes while pix_valid=1 and pix_ready=0, the new pixel is dropped, the held pixel is kept and err_overrun is set.
- Address counter:
  - pix_addr increments on each handshake (pix_valid & pix_ready).
  - At FRAME_PIX-1 a handshake wraps pix_addr to 0 and pulses frame_done in the same cycle as the handshake.
- clr_err clears the error flags. If clr_err coincides with a new error event, the event wins and the flag stays set.

## Timing
- Reset values:
  - pix_valid=0, pix_data=0, pix_addr=0, frame_done=0, err_frame=0, err_overrun=0
  - FSM in IDLE; byte index 0
- Reset mid-byte abandons the byte. A partial pixel is discarded.
- Latency: pix_valid rises 1 cycle after the stop-bit sample of the last byte of a pixel.
- Handshake: pix_valid remains high and pix_data/pix_addr remain stable until the cycle with pix_ready=1. pix_valid falls the next cycle unless a new pixel completes in that same cycle; in that case it stays high with new data and does not flag an overrun.
- pix_ready=1 while pix_valid=0 has no effect.
- Byte period is 10·BAUD_CNT cycles. The line tolerates ±2 % rate mismatch.

## Configuration
- UART_BREAK_SYNC_EN defined:
  - A break (byte 0x00 with a low stop bit) does not set err_frame.
  - Instead it resets the byte index to 0, drops any unhandshaken held pixel and forces pix_addr to 0. The host uses this to resynchronise the frame.
- UART_BREAK_SYNC_EN undefined: a break is an ordinary framing error: err_frame is set and there is no resynchronisation.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP)
  - the BAUD_CNT / half-BAUD_CNT computation function
  - the break byte constant 8'h00
- Sub-module uart_byte_rx contains the synchroniser, the receiver FSM and the baud counter. It outputs a byte, a byte_ok pulse, a byte_ferr pulse and an is_break pulse. Packer, holding register and address counter live in the top.

## Test plan
- BAUD_CNT=16, PIX_BYTES=1, pix_ready=1, send 0xA5 → one pix_valid pulse with pix_data=0x00A5, pix_addr=0, err flags 0.
- PIX_BYTES=2, send 0x34 then 0x12 → pix_data=0x1234 once, after the second stop bit, pix_addr=0. A following pixel gets pix_addr=1.
- pix_ready=0, send two pixels → first pixel held stable, err_overrun=1. Then pix_ready=1 → first pixel accepted. clr_err → err_overrun=0.
- FRAME_PIX=4, send 5 bytes → frame_done pulses with the 4th handshake, 5th pixel gets pix_addr=0.
- Stop bit driven low on 0x5A → no pix_valid, err_frame=1. A 1-cycle-wide low glitch on idle rx → FSM back to IDLE, no byte.
- Send 2 pixels then a break → with UART_BREAK_SYNC_EN the next pixel has pix_addr=0 and err_frame=0. Without the macro err_frame=1 and pix_addr continues at 2.
